// File: rtl/tile_step_ctl.sv
// tile_step_ctl: grid-locked movement controller for one sprite on the tile map.
// Takes button requests, checks the neighbouring tile against the wall bit
// vector, walks the sprite STEP pixels per movement tick until it is aligned on
// the next tile, and reports which neighbours of the current tile are blocked.
//
// Ports:
//   clk        pixel clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   tick       one-clk movement enable
//   up/down/left/right  direction requests (priority up > down > left > right)
//   center     respawn request (any cycle, no tick needed)
//   map        wall bits, index row*MAP_COLS+col, 1 = wall
//   x_pos/y_pos  sprite pixel position (top-left), registered
//   dir        last accepted direction: 0 up, 1 down, 2 left, 3 right
//   moving     high while a tile step is in progress
//   step_done  one-clk pulse when a tile step completes
//   collision  blocked neighbours of the current tile {up,down,left,right}
module tile_step_ctl #(
  parameter int MAP_COLS  = 15,
  parameter int MAP_ROWS  = 10,
  parameter int TILE      = 64,
  parameter int STEP      = 4,
  parameter int ORIGIN_X  = 32,
  parameter int ORIGIN_Y  = 64,
  parameter int START_COL = 0,
  parameter int START_ROW = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         up,
  input  logic                         down,
  input  logic                         left,
  input  logic                         right,
  input  logic                         center,
  input  logic [MAP_COLS*MAP_ROWS-1:0] map,
  output logic [11:0]                  x_pos,
  output logic [11:0]                  y_pos,
  output logic [1:0]                   dir,
  output logic                         moving,
  output logic                         step_done,
  output logic [3:0]                   collision
);

  localparam int COL_W = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
  localparam int ROW_W = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;
  localparam int OFF_W = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int IDX_W = (MAP_COLS * MAP_ROWS > 1) ? $clog2(MAP_COLS * MAP_ROWS) : 1;

  localparam logic [COL_W-1:0] C_COL_START = COL_W'(START_COL);
  localparam logic [ROW_W-1:0] C_ROW_START = ROW_W'(START_ROW);
  localparam logic [COL_W-1:0] C_COL_MAX   = COL_W'(MAP_COLS - 1);
  localparam logic [ROW_W-1:0] C_ROW_MAX   = ROW_W'(MAP_ROWS - 1);
  localparam logic [OFF_W-1:0] C_STEP      = OFF_W'(STEP);
  localparam logic [OFF_W-1:0] C_OFF_LAST  = OFF_W'(TILE - STEP);
  localparam logic [11:0]      C_X_START   = 12'(ORIGIN_X + START_COL * TILE);
  localparam logic [11:0]      C_Y_START   = 12'(ORIGIN_Y + START_ROW * TILE);

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_MOVE = 1'b1} state_t;

  state_t           r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [OFF_W-1:0] r_offset;
  logic [1:0]       r_dir;
  logic             r_moving;
  logic             r_step_done;
  logic [3:0]       r_collision;
  logic [11:0]      r_x_pos;
  logic [11:0]      r_y_pos;

  logic [3:0]       w_blocked;
  logic             w_req_valid;
  logic [1:0]       w_req_dir;
  logic             w_req_blocked;
  logic [COL_W-1:0] w_col_next;
  logic [ROW_W-1:0] w_row_next;
  logic [OFF_W-1:0] w_off_next;

  // Flat map index of an in-range tile.
  function automatic logic [IDX_W-1:0] f_idx(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    f_idx = IDX_W'(row) * IDX_W'(MAP_COLS) + IDX_W'(col);
  endfunction

  // Pixel x: horizontal moves carry the offset, vertical moves leave x on the tile.
  function automatic logic [11:0] f_pix_x(input logic [COL_W-1:0] col, input logic [OFF_W-1:0] off, input logic [1:0] d);
    logic [11:0] base;
    base = 12'(ORIGIN_X) + 12'(col) * 12'(TILE);
    case (d)
      D_RIGHT: f_pix_x = base + 12'(off);
      D_LEFT:  f_pix_x = base - 12'(off);
      default: f_pix_x = base;
    endcase
  endfunction

  // Pixel y: vertical moves carry the offset, horizontal moves leave y on the tile.
  function automatic logic [11:0] f_pix_y(input logic [ROW_W-1:0] row, input logic [OFF_W-1:0] off, input logic [1:0] d);
    logic [11:0] base;
    base = 12'(ORIGIN_Y) + 12'(row) * 12'(TILE);
    case (d)
      D_DOWN:  f_pix_y = base + 12'(off);
      D_UP:    f_pix_y = base - 12'(off);
      default: f_pix_y = base;
    endcase
  endfunction

  // Blocked neighbours; edge tests short-circuit so off-map indices never reach map.
  always_comb begin
    w_blocked = 4'b0000;
    if (r_row == ROW_W'(0)) w_blocked[3] = 1'b1;
    else                    w_blocked[3] = map[f_idx(r_row - ROW_W'(1), r_col)];
    if (r_row == C_ROW_MAX) w_blocked[2] = 1'b1;
    else                    w_blocked[2] = map[f_idx(r_row + ROW_W'(1), r_col)];
    if (r_col == COL_W'(0)) w_blocked[1] = 1'b1;
    else                    w_blocked[1] = map[f_idx(r_row, r_col - COL_W'(1))];
    if (r_col == C_COL_MAX) w_blocked[0] = 1'b1;
    else                    w_blocked[0] = map[f_idx(r_row, r_col + COL_W'(1))];
  end

  // Highest-priority request and whether its target tile is blocked.
  always_comb begin
    w_req_valid   = up | down | left | right;
    w_req_dir     = D_RIGHT;
    w_req_blocked = w_blocked[0];
    if (up) begin
      w_req_dir     = D_UP;
      w_req_blocked = w_blocked[3];
    end else if (down) begin
      w_req_dir     = D_DOWN;
      w_req_blocked = w_blocked[2];
    end else if (left) begin
      w_req_dir     = D_LEFT;
      w_req_blocked = w_blocked[1];
    end else begin
      w_req_dir     = D_RIGHT;
      w_req_blocked = w_blocked[0];
    end
  end

  // Destination tile of the step in progress and the advanced offset.
  always_comb begin
    w_col_next = r_col;
    w_row_next = r_row;
    w_off_next = r_offset + C_STEP;
    case (r_dir)
      D_UP:    w_row_next = r_row - ROW_W'(1);
      D_DOWN:  w_row_next = r_row + ROW_W'(1);
      D_LEFT:  w_col_next = r_col - COL_W'(1);
      D_RIGHT: w_col_next = r_col + COL_W'(1);
      default: w_col_next = r_col;
    endcase
  end

  // Movement FSM with registered position, direction and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col       <= C_COL_START;
      r_row       <= C_ROW_START;
      r_offset    <= OFF_W'(0);
      r_dir       <= D_UP;
      r_moving    <= 1'b0;
      r_step_done <= 1'b0;
      r_collision <= 4'b0000;
      r_x_pos     <= C_X_START;
      r_y_pos     <= C_Y_START;
    end else begin
      r_step_done <= 1'b0;
      // collision tracks the tile only while parked; it freezes during a step
      if (r_state == S_IDLE) r_collision <= w_blocked;
      if (center) begin
        r_state  <= S_IDLE;
        r_col    <= C_COL_START;
        r_row    <= C_ROW_START;
        r_offset <= OFF_W'(0);
        r_moving <= 1'b0;
        r_x_pos  <= C_X_START;
        r_y_pos  <= C_Y_START;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (tick && w_req_valid && !w_req_blocked) begin
              r_dir    <= w_req_dir;
              r_offset <= C_STEP;
              r_state  <= S_MOVE;
              r_moving <= 1'b1;
              r_x_pos  <= f_pix_x(r_col, C_STEP, w_req_dir);
              r_y_pos  <= f_pix_y(r_row, C_STEP, w_req_dir);
            end
          end
          S_MOVE: begin
            if (tick) begin
              if (r_offset == C_OFF_LAST) begin
                // offset would reach TILE: land on the neighbour, aligned
                r_col       <= w_col_next;
                r_row       <= w_row_next;
                r_offset    <= OFF_W'(0);
                r_state     <= S_IDLE;
                r_moving    <= 1'b0;
                r_step_done <= 1'b1;
                r_x_pos     <= f_pix_x(w_col_next, OFF_W'(0), r_dir);
                r_y_pos     <= f_pix_y(w_row_next, OFF_W'(0), r_dir);
              end else begin
                r_offset <= w_off_next;
                r_x_pos  <= f_pix_x(r_col, w_off_next, r_dir);
                r_y_pos  <= f_pix_y(r_row, w_off_next, r_dir);
              end
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_offset <= OFF_W'(0);
            r_moving <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x_pos     = r_x_pos;
  assign y_pos     = r_y_pos;
  assign dir       = r_dir;
  assign moving    = r_moving;
  assign step_done = r_step_done;
  assign collision = r_collision;

endmodule

// File: tb/tb_tile_step_ctl.sv
// tb_tile_step_ctl: self-checking bench for tile_step_ctl with default parameters.
// Each applied cycle pushes its expected outputs onto a scoreboard queue; the
// entry is popped and compared one time unit after the rising edge.
module tb_tile_step_ctl;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         up;
  logic         down;
  logic         left;
  logic         right;
  logic         center;
  logic [149:0] map;
  logic [11:0]  x_pos;
  logic [11:0]  y_pos;
  logic [1:0]   dir;
  logic         moving;
  logic         step_done;
  logic [3:0]   collision;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  d;
    logic        m;
    logic        s;
    logic [3:0]  c;
  } exp_t;

  typedef struct {
    string      name;
    logic       r, t, u, dn, l, rt, c, wall;
    int         ex, ey, ed, em, es;
    logic [3:0] ec;
  } vec_t;

  exp_t sb[$];
  vec_t tab_a[4];
  vec_t tab_b[6];

  tile_step_ctl dut (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .down(down), .left(left),
    .right(right), .center(center), .map(map), .x_pos(x_pos), .y_pos(y_pos),
    .dir(dir), .moving(moving), .step_done(step_done), .collision(collision)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input string nm, input logic r, t, u, dn, l, rt, c, wall,
                              input int ex, ey, ed, em, es, input logic [3:0] ec);
    vec_t v;
    v.name = nm; v.r = r; v.t = t; v.u = u; v.dn = dn; v.l = l; v.rt = rt; v.c = c;
    v.wall = wall; v.ex = ex; v.ey = ey; v.ed = ed; v.em = em; v.es = es; v.ec = ec;
    return v;
  endfunction

  task automatic check_front();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected entry, got x=%0d y=%0d", x_pos, y_pos);
    end else begin
      e = sb.pop_front();
      if (x_pos !== e.x || y_pos !== e.y || dir !== e.d || moving !== e.m ||
          step_done !== e.s || collision !== e.c) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d dir=%0d moving=%0b step_done=%0b collision=%b, expected x=%0d y=%0d dir=%0d moving=%0b step_done=%0b collision=%b",
                 e.name, x_pos, y_pos, dir, moving, step_done, collision,
                 e.x, e.y, e.d, e.m, e.s, e.c);
      end
    end
  endtask

  // One clock: drive inputs on the falling edge, queue the expectation, compare after the rising edge.
  task automatic run(input string nm, input logic r, t, u, dn, l, rt, c,
                     input int ex, ey, ed, em, es, input logic [3:0] ec);
    exp_t e;
    @(negedge clk);
    rst = r; tick = t; up = u; down = dn; left = l; right = rt; center = c;
    e.name = nm; e.x = 12'(ex); e.y = 12'(ey); e.d = 2'(ed);
    e.m = 1'(em); e.s = 1'(es); e.c = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic apply_vec(input vec_t v);
    map[1] = v.wall;
    run(v.name, v.r, v.t, v.u, v.dn, v.l, v.rt, v.c, v.ex, v.ey, v.ed, v.em, v.es, v.ec);
  endtask

  // A tile step of nticks ticks, each tick preceded by gap idle cycles.
  // req is {up,down,left,right}; released after the first tick unless hold.
  task automatic step_seq(input string nm, input logic [3:0] req, input bit hold,
                          input int nticks, gap, x0, y0, dx, dy, d0, dn,
                          input logic [3:0] coll);
    logic [3:0] rq;
    for (int k = 1; k <= nticks; k++) begin
      rq = 4'b0000;
      if (k == 1 || hold) rq = req;
      for (int j = 0; j < gap; j++) begin
        if (k == 1)
          run($sformatf("%s_pre%0d", nm, k), 1'b0, 1'b0, rq[3], rq[2], rq[1], rq[0], 1'b0,
              x0, y0, d0, 0, 0, coll);
        else
          run($sformatf("%s_pre%0d", nm, k), 1'b0, 1'b0, rq[3], rq[2], rq[1], rq[0], 1'b0,
              x0 + dx * 4 * (k - 1), y0 + dy * 4 * (k - 1), dn, 1, 0, coll);
      end
      if (k == 16)
        run($sformatf("%s_tick%0d", nm, k), 1'b0, 1'b1, rq[3], rq[2], rq[1], rq[0], 1'b0,
            x0 + dx * 64, y0 + dy * 64, dn, 0, 1, coll);
      else
        run($sformatf("%s_tick%0d", nm, k), 1'b0, 1'b1, rq[3], rq[2], rq[1], rq[0], 1'b0,
            x0 + dx * 4 * k, y0 + dy * 4 * k, dn, 1, 0, coll);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    center = 1'b0; map = '0;

    // reset state; collision appears one idle clock after reset
    tab_a[0] = mk("reset",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32, 64, 0, 0, 0, 4'b0000);
    tab_a[1] = mk("reset_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32, 64, 0, 0, 0, 4'b0000);
    tab_a[2] = mk("reset_coll", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32, 64, 0, 0, 0, 4'b1010);
    tab_a[3] = mk("idle_coll",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32, 64, 0, 0, 0, 4'b1010);
    // wall at (row 0, col 1): right is refused, dir stays 0
    tab_b[0] = mk("blk_reset",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32, 64, 0, 0, 0, 4'b0000);
    tab_b[1] = mk("blk_tick1",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32, 64, 0, 0, 0, 4'b1011);
    tab_b[2] = mk("blk_hold1",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32, 64, 0, 0, 0, 4'b1011);
    tab_b[3] = mk("blk_tick2",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32, 64, 0, 0, 0, 4'b1011);
    tab_b[4] = mk("blk_hold2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32, 64, 0, 0, 0, 4'b1011);
    tab_b[5] = mk("blk_tick3",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32, 64, 0, 0, 0, 4'b1011);

    for (int i = 0; i < 4; i++) apply_vec(tab_a[i]);

    // right held, tick every 8 clocks: (0,0) -> (0,1)
    step_seq("right_hold", 4'b0001, 1'b1, 16, 7, 32, 64, 1, 0, 0, 3, 4'b1010);
    run("right_done_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 96, 64, 3, 0, 0, 4'b1000);
    run("right_done_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 96, 64, 3, 0, 0, 4'b1000);

    for (int i = 0; i < 6; i++) apply_vec(tab_b[i]);

    // clear the wall, walk down to (1,0)
    map = '0;
    step_seq("down_r1", 4'b0100, 1'b1, 16, 1, 32, 64, 0, 1, 0, 1, 4'b1010);
    run("at_r1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32, 128, 1, 0, 0, 4'b0010);

    // up and right together: up wins
    step_seq("up_right", 4'b1001, 1'b1, 16, 1, 32, 128, 0, -1, 1, 0, 4'b0010);
    run("back_r0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32, 64, 0, 0, 0, 4'b1010);

    // right tapped for one tick: step still completes
    step_seq("right_tap", 4'b0001, 1'b0, 16, 1, 32, 64, 1, 0, 0, 3, 4'b1010);
    run("tap_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 96, 64, 3, 0, 0, 4'b1000);

    // new down request accepted, stopped at offset 24 by center (tick and right also high)
    step_seq("down_part", 4'b0100, 1'b1, 6, 1, 96, 64, 0, 1, 3, 1, 4'b1000);
    run("center_mid", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32, 64, 1, 0, 0, 4'b1000);
    run("center_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32, 64, 1, 0, 0, 4'b1010);

    // right step stopped at offset 24 by rst together with center
    step_seq("right_part", 4'b0001, 1'b1, 6, 1, 32, 64, 1, 0, 1, 3, 4'b1010);
    run("rst_mid", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32, 64, 0, 0, 0, 4'b0000);
    run("rst_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32, 64, 0, 0, 0, 4'b1010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
